fp_pipe_reg: RTL and testbench

Parametrised elastic pipeline register with valid/ready handshake, the successor to the single-stage enable register used between floating-point adder/subtractor stages. It holds up to DEPTH words of WIDTH bits in a chain of stages. Each stage advances independently, so bubbles collapse and a downstream stall backs data up without loss. It adds a synchronous flush and an occupancy count, and is placed between the align, add/sub, normalise and round stages.

---
 rtl/fp_pipe_reg_if.sv | 27 ++
 rtl/fp_pipe_reg.sv | 77 +++++++
 tb/tb_fp_pipe_reg.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fp_pipe_reg_if.sv
// Handshake bundle for fp_pipe_reg: upstream valid/ready/data, downstream valid/ready/data,
// flush and occupancy. The slave modport is the pipeline register itself.
interface fp_pipe_reg_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] data_o;
  logic [CW-1:0]    count_o;

  modport master (
    output flush_i, in_valid_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, count_o
  );

  modport slave (
    input  flush_i, in_valid_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, count_o
  );
endinterface

// File: rtl/fp_pipe_reg.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake, synchronous flush and a
// registered occupancy count; each stage advances on its own so bubbles collapse under stall.
module fp_pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic          clk50M,
  input logic          rst,
  fp_pipe_reg_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_r;
  logic [WIDTH-1:0] d_r [DEPTH];
  logic [CW-1:0]    count_r;
  logic [DEPTH:0]   rdy_s;
  logic             acc_s;
  logic             accept_s;
  logic             emit_s;

  // Ready chain: a stage can take a word if it is empty or anything downstream can move.
  always_comb begin
    acc_s        = bus.out_ready_i;
    rdy_s        = '0;
    rdy_s[DEPTH] = bus.out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc_s    = acc_s | ~v_r[k];
      rdy_s[k] = acc_s;
    end
  end

  // Upstream/downstream handshake qualifiers.
  always_comb begin
    if (bus.flush_i) begin
      bus.in_ready_o = 1'b0;
    end else begin
      bus.in_ready_o = rdy_s[0];
    end
    accept_s = bus.in_valid_i & bus.in_ready_o;
    emit_s   = v_r[DEPTH-1] & bus.out_ready_i;
  end

  // Stage chain and occupancy; flush only clears valid bits, data regs keep their contents.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      v_r     <= '0;
      count_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_r[k] <= RESET_VAL;
      end
    end else if (bus.flush_i) begin
      v_r     <= '0;
      count_r <= '0;
    end else begin
      if (rdy_s[0]) begin
        v_r[0] <= accept_s;
        if (accept_s) begin
          d_r[0] <= bus.data_i;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (rdy_s[k]) begin
          v_r[k] <= v_r[k-1];
          if (v_r[k-1]) begin
            d_r[k] <= d_r[k-1];
          end
        end
      end
      count_r <= count_r + CW'(accept_s) - CW'(emit_s);
    end
  end

  assign bus.out_valid_o = v_r[DEPTH-1];
  assign bus.data_o      = d_r[DEPTH-1];
  assign bus.count_o     = count_r;
endmodule

// File: tb/tb_fp_pipe_reg.sv
// Directed bench for fp_pipe_reg (DEPTH=3, WIDTH=32): reset, latency, backpressure,
// pass-through at full occupancy, bubble collapse and flush.
module tb_fp_pipe_reg;
  localparam int WIDTH = 32;
  localparam int DEPTH = 3;

  logic clk50M = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  fp_pipe_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fp_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(32'h0000_0000)) dut (
    .clk50M(clk50M),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk50M = ~clk50M;

  task automatic tick;
    @(posedge clk50M);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0; bus.data_i = 32'h0;
    #3;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid_o); end
    total++; if (bus.data_o !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.data_o); end
    total++; if (bus.count_o !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.count_o); end
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.in_ready_o); end
    tick;
    rst = 1'b0;
    tick;
    bus.in_valid_i = 1'b1; bus.data_i = 32'h0000_00AA;
    tick;
    bus.data_i = 32'h0000_00BB;
    tick;
    bus.in_valid_i = 1'b0;
    total++; if (bus.count_o !== 2'd2) begin bad++; $display("FAIL pre_rst_count got=%0d want=2", bus.count_o); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", bus.out_valid_o); end
    total++; if (bus.data_o !== 32'h0) begin bad++; $display("FAIL mid_rst_data got=%h want=0", bus.data_o); end
    total++; if (bus.count_o !== 2'd0) begin bad++; $display("FAIL mid_rst_count got=%0d want=0", bus.count_o); end
    #1 rst = 1'b0;
    #1;
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", bus.in_ready_o); end
    tick;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b want=0", bus.out_valid_o); end
  endtask

  task automatic test_latency;
    bus.out_ready_i = 1'b1;
    bus.in_valid_i = 1'b1; bus.data_i = 32'h3F80_0000;
    tick;
    total++; if (bus.out_valid_o !== 1'b0 || bus.count_o !== 2'd1) begin bad++; $display("FAIL lat_e1 got v=%b c=%0d want v=0 c=1", bus.out_valid_o, bus.count_o); end
    bus.data_i = 32'h4000_0000;
    tick;
    total++; if (bus.out_valid_o !== 1'b0 || bus.count_o !== 2'd2) begin bad++; $display("FAIL lat_e2 got v=%b c=%0d want v=0 c=2", bus.out_valid_o, bus.count_o); end
    bus.data_i = 32'h4040_0000;
    tick;
    bus.in_valid_i = 1'b0;
    total++; if (bus.out_valid_o !== 1'b1 || bus.data_o !== 32'h3F80_0000 || bus.count_o !== 2'd3) begin bad++; $display("FAIL lat_e3 got v=%b d=%h c=%0d want v=1 d=3f800000 c=3", bus.out_valid_o, bus.data_o, bus.count_o); end
    tick;
    total++; if (bus.out_valid_o !== 1'b1 || bus.data_o !== 32'h4000_0000 || bus.count_o !== 2'd2) begin bad++; $display("FAIL lat_e4 got v=%b d=%h c=%0d want v=1 d=40000000 c=2", bus.out_valid_o, bus.data_o, bus.count_o); end
    tick;
    total++; if (bus.out_valid_o !== 1'b1 || bus.data_o !== 32'h4040_0000 || bus.count_o !== 2'd1) begin bad++; $display("FAIL lat_e5 got v=%b d=%h c=%0d want v=1 d=40400000 c=1", bus.out_valid_o, bus.data_o, bus.count_o); end
    tick;
    total++; if (bus.out_valid_o !== 1'b0 || bus.count_o !== 2'd0) begin bad++; $display("FAIL lat_e6 got v=%b c=%0d want v=0 c=0", bus.out_valid_o, bus.count_o); end
  endtask

  // Leaves the pipe full with A,B,C and D offered; test_pass_through continues from here.
  task automatic test_backpressure;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1; bus.data_i = 32'hA000_000A;
    #1;
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b want=1", bus.in_ready_o); end
    tick;
    bus.data_i = 32'hB000_000B;
    tick;
    bus.data_i = 32'hC000_000C;
    #1;
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready3 got=%b want=1", bus.in_ready_o); end
    tick;
    bus.data_i = 32'hD000_000D;
    #1;
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready4 got=%b want=0", bus.in_ready_o); end
    total++; if (bus.count_o !== 2'd3) begin bad++; $display("FAIL bp_count got=%0d want=3", bus.count_o); end
    total++; if (bus.out_valid_o !== 1'b1 || bus.data_o !== 32'hA000_000A) begin bad++; $display("FAIL bp_head got v=%b d=%h want v=1 d=a000000a", bus.out_valid_o, bus.data_o); end
    tick;
    tick;
    total++; if (bus.in_ready_o !== 1'b0 || bus.count_o !== 2'd3 || bus.data_o !== 32'hA000_000A) begin bad++; $display("FAIL bp_hold got r=%b c=%0d d=%h want r=0 c=3 d=a000000a", bus.in_ready_o, bus.count_o, bus.data_o); end
  endtask

  task automatic test_pass_through;
    bus.out_ready_i = 1'b1;
    #1;
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL pt_ready got=%b want=1", bus.in_ready_o); end
    tick;
    total++; if (bus.data_o !== 32'hB000_000B || bus.count_o !== 2'd3) begin bad++; $display("FAIL pt_e1 got d=%h c=%0d want d=b000000b c=3", bus.data_o, bus.count_o); end
    bus.data_i = 32'hE000_000E;
    tick;
    bus.in_valid_i = 1'b0;
    total++; if (bus.data_o !== 32'hC000_000C || bus.count_o !== 2'd3) begin bad++; $display("FAIL pt_e2 got d=%h c=%0d want d=c000000c c=3", bus.data_o, bus.count_o); end
    tick;
    total++; if (bus.data_o !== 32'hD000_000D || bus.count_o !== 2'd2) begin bad++; $display("FAIL pt_e3 got d=%h c=%0d want d=d000000d c=2", bus.data_o, bus.count_o); end
    tick;
    total++; if (bus.out_valid_o !== 1'b1 || bus.data_o !== 32'hE000_000E || bus.count_o !== 2'd1) begin bad++; $display("FAIL pt_e4 got v=%b d=%h c=%0d want v=1 d=e000000e c=1", bus.out_valid_o, bus.data_o, bus.count_o); end
    tick;
    total++; if (bus.out_valid_o !== 1'b0 || bus.count_o !== 2'd0) begin bad++; $display("FAIL pt_e5 got v=%b c=%0d want v=0 c=0", bus.out_valid_o, bus.count_o); end
  endtask

  task automatic test_bubble;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1; bus.data_i = 32'h0000_A1A1;
    tick;
    bus.in_valid_i = 1'b0;
    tick;
    tick;
    bus.in_valid_i = 1'b1; bus.data_i = 32'h0000_B2B2;
    tick;
    bus.in_valid_i = 1'b0;
    repeat (4) tick;
    total++; if (bus.count_o !== 2'd2) begin bad++; $display("FAIL bub_count got=%0d want=2", bus.count_o); end
    total++; if (bus.out_valid_o !== 1'b1 || bus.data_o !== 32'h0000_A1A1) begin bad++; $display("FAIL bub_head got v=%b d=%h want v=1 d=0000a1a1", bus.out_valid_o, bus.data_o); end
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL bub_ready got=%b want=1", bus.in_ready_o); end
    bus.out_ready_i = 1'b1;
    tick;
    total++; if (bus.out_valid_o !== 1'b1 || bus.data_o !== 32'h0000_B2B2 || bus.count_o !== 2'd1) begin bad++; $display("FAIL bub_second got v=%b d=%h c=%0d want v=1 d=0000b2b2 c=1", bus.out_valid_o, bus.data_o, bus.count_o); end
    tick;
    total++; if (bus.out_valid_o !== 1'b0 || bus.count_o !== 2'd0) begin bad++; $display("FAIL bub_empty got v=%b c=%0d want v=0 c=0", bus.out_valid_o, bus.count_o); end
  endtask

  task automatic test_flush;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1; bus.data_i = 32'h1111_1111;
    tick;
    bus.data_i = 32'h2222_2222;
    tick;
    bus.data_i = 32'h3333_3333;
    tick;
    total++; if (bus.count_o !== 2'd3) begin bad++; $display("FAIL fl_fill got=%0d want=3", bus.count_o); end
    bus.flush_i = 1'b1; bus.data_i = 32'h4444_4444; bus.out_ready_i = 1'b1;
    #1;
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b want=0", bus.in_ready_o); end
    total++; if (bus.out_valid_o !== 1'b1 || bus.data_o !== 32'h1111_1111) begin bad++; $display("FAIL fl_head got v=%b d=%h want v=1 d=11111111", bus.out_valid_o, bus.data_o); end
    tick;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    total++; if (bus.out_valid_o !== 1'b0 || bus.count_o !== 2'd0) begin bad++; $display("FAIL fl_after got v=%b c=%0d want v=0 c=0", bus.out_valid_o, bus.count_o); end
    for (int i = 0; i < 5; i++) begin
      tick;
      total++; if (bus.out_valid_o !== 1'b0 || bus.count_o !== 2'd0) begin bad++; $display("FAIL fl_quiet%0d got v=%b c=%0d want v=0 c=0", i, bus.out_valid_o, bus.count_o); end
    end
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL fl_ready_after got=%b want=1", bus.in_ready_o); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_backpressure;
    test_pass_through;
    test_bubble;
    test_flush;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
